// File: rtl/m_ext_defs.sv
// m_ext_defs: shared types and constants for the EXE->M-extension interface.
package m_ext_defs;
    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [3:0] {
        M_NONE, M_MUL, M_MULH, M_MULHSU, M_MULHU, M_DIV, M_DIVU, M_REM, M_REMU
    } type_alu_m_ops_e;

    typedef struct packed {
        logic [MD_XLEN-1:0] alu_operand_1;
        logic [MD_XLEN-1:0] alu_operand_2;
        type_alu_m_ops_e    alu_m_ops;
    } type_exe2mul_s;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} type_mul_state_e;

    localparam logic [MD_XLEN-1:0] DIV_ZERO_Q = '1;
    localparam logic [MD_XLEN-1:0] SIGNED_MIN = 32'h8000_0000;

    // Encodings outside the enumerated range behave as M_NONE.
    function automatic logic is_m_op(input type_alu_m_ops_e op);
        return op >= M_MUL && op <= M_REMU;
    endfunction
endpackage

// File: rtl/mul_div_divider.sv
// mul_div_divider: iterative radix-2 restoring unsigned divider, one quotient bit per cycle.
module mul_div_divider #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic [XLEN:0]    trial;

    assign busy_o      = cnt_q != '0;
    assign done_o      = cnt_q == CNT_W'(1);
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dvs_d = dvs_q;
        if (kill_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = CNT_W'(XLEN);
            quo_d = dividend_i;
            rem_d = '0;
            dvs_d = divisor_i;
        end else if (busy_o) begin
            // A borrow means the trial subtraction failed: keep the shifted remainder.
            cnt_d = cnt_q - CNT_W'(1);
            quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
            rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: RV32M multiply/divide unit; stalls EXE while busy and strobes one result.
module mul_div_unit
    import m_ext_defs::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  type_exe2mul_s   exe2mul_i,
    input  logic            flush_i,
    output logic            mul_stall_o,
    output logic [XLEN-1:0] mul_result_o,
    output logic            mul_valid_o
);
    type_mul_state_e   state_q, state_d;
    type_alu_m_ops_e   op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0] prod_q, prod_d, ma, mb;
    logic [XLEN-1:0]   in_a, in_b, abs_a, abs_b, div_quo, div_rem;
    logic [XLEN-1:0]   q_fix, r_fix, div_res, mul_res;
    logic              req, in_mul, in_sgn, in_special, div_start, div_kill, div_busy, div_done;
    logic              q_is_mul, q_is_quo, q_sgn, q_zero, q_ovf;

    assign in_a       = exe2mul_i.alu_operand_1;
    assign in_b       = exe2mul_i.alu_operand_2;
    assign req        = is_m_op(exe2mul_i.alu_m_ops) && !flush_i;
    assign in_mul     = exe2mul_i.alu_m_ops >= M_MUL && exe2mul_i.alu_m_ops <= M_MULHU;
    assign in_sgn     = exe2mul_i.alu_m_ops == M_DIV || exe2mul_i.alu_m_ops == M_REM;
    assign in_special = in_b == '0 || (in_sgn && in_a == SIGNED_MIN && in_b == '1);
    assign abs_a      = (in_sgn && in_a[XLEN-1]) ? -in_a : in_a;
    assign abs_b      = (in_sgn && in_b[XLEN-1]) ? -in_b : in_b;
    assign div_start  = state_q == S_IDLE && req && !in_mul && !in_special;
    assign div_kill   = state_q == S_DIV && flush_i;

    mul_div_divider #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .kill_i     (div_kill),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quo),
        .remainder_o(div_rem)
    );

    // Sign-extending to 2*XLEN keeps the low 2*XLEN product bits exact for every variant.
    assign ma = {{XLEN{op_q != M_MULHU && a_q[XLEN-1]}}, a_q};
    assign mb = {{XLEN{(op_q == M_MUL || op_q == M_MULH) && b_q[XLEN-1]}}, b_q};

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: if (req) begin
                op_d    = exe2mul_i.alu_m_ops;
                a_d     = in_a;
                b_d     = in_b;
                state_d = in_mul ? S_MUL : in_special ? S_DONE : S_DIV;
            end
            S_MUL: begin
                prod_d  = ma * mb;
                state_d = flush_i ? S_IDLE : S_DONE;
            end
            S_DIV:   state_d = flush_i ? S_IDLE : div_done ? S_DONE : S_DIV;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= M_NONE;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign q_is_mul = op_q >= M_MUL && op_q <= M_MULHU;
    assign q_is_quo = op_q == M_DIV || op_q == M_DIVU;
    assign q_sgn    = op_q == M_DIV || op_q == M_REM;
    assign q_zero   = b_q == '0;
    assign q_ovf    = q_sgn && a_q == SIGNED_MIN && b_q == '1;
    assign q_fix    = (q_sgn && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_quo : div_quo;
    assign r_fix    = (q_sgn && a_q[XLEN-1]) ? -div_rem : div_rem;
    assign div_res  = q_zero ? (q_is_quo ? DIV_ZERO_Q : a_q)
                    : q_ovf  ? (q_is_quo ? SIGNED_MIN : '0)
                    : (q_is_quo ? q_fix : r_fix);
    assign mul_res  = op_q == M_MUL ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];

    assign mul_valid_o  = state_q == S_DONE;
    assign mul_result_o = mul_valid_o ? (q_is_mul ? mul_res : div_res) : '0;
    assign mul_stall_o  = (state_q == S_IDLE && req) || state_q == S_MUL
                        || (state_q == S_DIV && div_busy);
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed-vector self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import m_ext_defs::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    type_exe2mul_s exe;
    logic          stall, valid;
    logic [31:0]   result;
    int            n_chk = 0;
    int            n_err = 0;
    int            vcnt;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exe2mul_i   (exe),
        .flush_i     (flush),
        .mul_stall_o (stall),
        .mul_result_o(result),
        .mul_valid_o (valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input type_alu_m_ops_e op, input logic [31:0] a, input logic [31:0] b);
        exe.alu_m_ops     = op;
        exe.alu_operand_1 = a;
        exe.alu_operand_2 = b;
    endtask

    // Issues an op in the next cycle (C0) and checks stall/valid at C0, C(lat-1) and C(lat).
    task automatic run_op(input string tag, input type_alu_m_ops_e op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp);
        @(posedge clk); #1;
        drive(op, a, b);
        #1;
        chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
        chk({tag, "_c0_valid"}, 32'(valid), 32'd0);
        if (lat > 1) begin
            repeat (lat - 1) @(posedge clk);
            #2;
            chk({tag, "_pre_stall"}, 32'(stall), 32'd1);
            chk({tag, "_pre_valid"}, 32'(valid), 32'd0);
        end
        @(posedge clk); #2;
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_result"}, result, exp);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        drive(M_NONE, 32'd0, 32'd0);
        #1;
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(M_NONE, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_result", result, 32'd0);
        rst_n = 1'b1;

        run_op("mul", M_MUL, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);
        go_idle();
        run_op("mulh", M_MULH, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
        run_op("mulhu", M_MULHU, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000);
        run_op("mulhsu", M_MULHSU, 32'h8000_0000, 32'h8000_0000, 2, 32'hC000_0000);
        run_op("mulhu_ff", M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        run_op("mul_ff", M_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0001);
        go_idle();

        run_op("div_neg", M_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        run_op("rem_neg", M_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        run_op("divu", M_DIVU, 32'd100, 32'd7, 33, 32'd14);
        run_op("remu", M_REMU, 32'd100, 32'd7, 33, 32'd2);
        run_op("div_negb", M_DIV, 32'd20, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFA);
        run_op("rem_negb", M_REM, 32'd20, 32'hFFFF_FFFD, 33, 32'd2);
        go_idle();

        run_op("div_zero", M_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("remu_zero", M_REMU, 32'd5, 32'd0, 1, 32'd5);
        run_op("divu_zero", M_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run_op("div_ovf", M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run_op("rem_ovf", M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        go_idle();

        @(posedge clk); #1;
        drive(M_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        drive(M_NONE, 32'd0, 32'd0);
        #1;
        chk("flush_c10_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("flush_c11_stall", 32'(stall), 32'd0);
        vcnt = 0;
        repeat (30) begin
            @(posedge clk); #2;
            if (valid) vcnt++;
        end
        chk("flush_no_valid", 32'(vcnt), 32'd0);
        run_op("mul_after_flush", M_MUL, 32'd3, 32'd4, 2, 32'd12);
        go_idle();

        @(posedge clk); #1;
        drive(M_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(M_NONE, 32'd0, 32'd0);
        @(posedge clk); #2;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(S_IDLE));
        rst_n = 1'b1;
        vcnt = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (valid) vcnt++;
        end
        chk("midrst_no_valid", 32'(vcnt), 32'd0);

        run_op("b2b_mul", M_MUL, 32'd6, 32'd7, 2, 32'd42);
        run_op("b2b_divu", M_DIVU, 32'd1000, 32'd10, 33, 32'd100);
        go_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
